// File: rtl/xor_32bit_pkg.sv
// ---------------------------------------------------------------------------
// xor_32bit_pkg
//   Shared constants for the XOR datapath block.
//   XOR_WIDTH : default operand/result width.
//   XOR_CNT_W : width needed to count 0..XOR_WIDTH set bits.
// ---------------------------------------------------------------------------
package xor_32bit_pkg;

  localparam int XOR_WIDTH = 32;
  localparam int XOR_CNT_W = $clog2(XOR_WIDTH + 1);

endpackage : xor_32bit_pkg

// File: rtl/xor_32bit_unit_popcount_32.sv
// ---------------------------------------------------------------------------
// popcount_32
//   Purely combinational population count, built as a balanced binary adder
//   tree. Leaves are padded with zeros up to the next power of two, so any
//   WIDTH >= 1 works.
//
//   Ports
//     vec_i  in  WIDTH  vector to count
//     cnt_o  out CNT_W  number of 1 bits in vec_i
// ---------------------------------------------------------------------------
module popcount_32
  import xor_32bit_pkg::*;
#(
  parameter  int WIDTH = XOR_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int N      = 1 << LEVELS;

  // Heap-ordered tree: node k sums children 2k and 2k+1, leaves at N..2N-1,
  // root at 1. Every node is CNT_W wide; no partial sum can exceed WIDTH.
  logic [2*N-1:1][CNT_W-1:0] tree;

  genvar i, k;
  generate
    for (i = 0; i < N; i++) begin : g_leaf
      if (i < WIDTH) begin : g_bit
        assign tree[N+i] = CNT_W'(vec_i[i]);
      end else begin : g_pad
        assign tree[N+i] = '0;
      end
    end

    for (k = 1; k < N; k++) begin : g_node
      assign tree[k] = tree[2*k] + tree[2*k+1];
    end
  endgenerate

  assign cnt_o = tree[1];

endmodule : popcount_32

// File: rtl/xor_32bit_unit.sv
// ---------------------------------------------------------------------------
// xor_32bit_unit
//   Bitwise XOR datapath. c_o is the combinational result; a one-cycle
//   registered side stage captures the result with zero/parity/popcount
//   flags and a valid pulse for pipelined consumers.
//
//   Optional feature (macro XOR_32BIT_CHECKSUM_EN): adds clr_i and acc_o,
//   a running XOR checksum over every accepted result.
//
//   Ports
//     clk_i      in  1      clock, rising edge
//     rst_i      in  1      synchronous reset, active high
//     a_i, b_i   in  WIDTH  operands
//     c_o        out WIDTH  a_i ^ b_i (combinational)
//     valid_i    in  1      capture request
//     valid_o    out 1      registered result valid (one-cycle pulse)
//     c_q_o      out WIDTH  registered result
//     zero_q_o   out 1      registered result == 0
//     parity_q_o out 1      registered reduction XOR of result
//     ones_q_o   out CNT_W  registered popcount of result
//     clr_i      in  1      checksum clear        (checksum build only)
//     acc_o      out WIDTH  running XOR checksum  (checksum build only)
// ---------------------------------------------------------------------------
module xor_32bit_unit
  import xor_32bit_pkg::*;
#(
  parameter  int WIDTH = XOR_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] c_o,
  input  logic             valid_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] c_q_o,
  output logic             zero_q_o,
  output logic             parity_q_o,
  output logic [CNT_W-1:0] ones_q_o
`ifdef XOR_32BIT_CHECKSUM_EN
  ,
  input  logic             clr_i,
  output logic [WIDTH-1:0] acc_o
`endif
);

  // Combinational result; also feeds the registered stage.
  logic [WIDTH-1:0] x;
  logic [CNT_W-1:0] ones;

  assign x   = a_i ^ b_i;
  assign c_o = x;

  popcount_32 #(.WIDTH(WIDTH)) u_popcount (
    .vec_i (x),
    .cnt_o (ones)
  );

  // -------------------------------------------------------------------------
  // Registered stage
  // -------------------------------------------------------------------------
  logic             valid_d,  valid_q;
  logic [WIDTH-1:0] c_d,      c_q;
  logic             zero_d,   zero_q;
  logic             parity_d, parity_q;
  logic [CNT_W-1:0] ones_d,   ones_q;

  always_comb begin
    valid_d  = 1'b0;           // pulse: drops unless a new capture arrives
    c_d      = c_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    ones_d   = ones_q;
    if (valid_i) begin
      valid_d  = 1'b1;
      c_d      = x;
      // Compare operands directly so X/Z on either side shows up in the flag.
      zero_d   = (a_i == b_i);
      parity_d = ^x;
      ones_d   = ones;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      c_q      <= '0;
      zero_q   <= 1'b1;        // reset result is 0, so the zero flag is set
      parity_q <= 1'b0;
      ones_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      c_q      <= c_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      ones_q   <= ones_d;
    end
  end

  assign valid_o    = valid_q;
  assign c_q_o      = c_q;
  assign zero_q_o   = zero_q;
  assign parity_q_o = parity_q;
  assign ones_q_o   = ones_q;

`ifdef XOR_32BIT_CHECKSUM_EN
  // -------------------------------------------------------------------------
  // Running checksum. Reset and clr_i both win over an accepted result.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (valid_i) begin
      acc_d = acc_q ^ x;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
`endif

endmodule : xor_32bit_unit

// File: tb/tb_xor_32bit_unit.sv
`timescale 1ns/1ps
module tb_xor_32bit_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] a_i, b_i;
  logic [31:0] c_o;
  logic        valid_i;
  logic        valid_o;
  logic [31:0] c_q_o;
  logic        zero_q_o;
  logic        parity_q_o;
  logic [5:0]  ones_q_o;
`ifdef XOR_32BIT_CHECKSUM_EN
  logic        clr_i;
  logic [31:0] acc_o;
`endif

  int passed = 0;
  int total  = 0;

  xor_32bit_unit dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .c_o        (c_o),
    .valid_i    (valid_i),
    .valid_o    (valid_o),
    .c_q_o      (c_q_o),
    .zero_q_o   (zero_q_o),
    .parity_q_o (parity_q_o),
    .ones_q_o   (ones_q_o)
`ifdef XOR_32BIT_CHECKSUM_EN
    ,
    .clr_i      (clr_i),
    .acc_o      (acc_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    a_i     = 32'h1234_0000;
    b_i     = 32'h0000_5678;
`ifdef XOR_32BIT_CHECKSUM_EN
    clr_i   = 1'b0;
`endif
    tick();
    tick();
    // reset state; combinational path live during reset
    check("rst_c_o",    c_o,               32'h1234_5678);
    check("rst_valid",  {31'd0, valid_o},   32'd0);
    check("rst_c_q",    c_q_o,              32'd0);
    check("rst_zero",   {31'd0, zero_q_o},  32'd1);
    check("rst_parity", {31'd0, parity_q_o},32'd0);
    check("rst_ones",   {26'd0, ones_q_o},  32'd0);
`ifdef XOR_32BIT_CHECKSUM_EN
    check("rst_acc",    acc_o,              32'd0);
`endif
    rst_i = 1'b0;

    // random combinational sweep, 50 ns per vector
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      a_i = ra;
      b_i = rb;
      #1;
      check("sweep_c_o", c_o, ra ^ rb);
      #49;
    end
    tick();
    check("idle_valid", {31'd0, valid_o}, 32'd0);

    // identical operands
    a_i = 32'hDEAD_BEEF; b_i = 32'hDEAD_BEEF; valid_i = 1'b1;
    #1;
    check("ident_c_o", c_o, 32'd0);
    tick();
    check("ident_valid",  {31'd0, valid_o},    32'd1);
    check("ident_c_q",    c_q_o,               32'd0);
    check("ident_zero",   {31'd0, zero_q_o},   32'd1);
    check("ident_parity", {31'd0, parity_q_o}, 32'd0);
    check("ident_ones",   {26'd0, ones_q_o},   32'd0);

    // complement, back-to-back capture
    a_i = 32'h0000_FFFF; b_i = 32'hFFFF_0000;
    #1;
    check("comp_c_o", c_o, 32'hFFFF_FFFF);
    tick();
    check("comp_valid",  {31'd0, valid_o},    32'd1);
    check("comp_c_q",    c_q_o,               32'hFFFF_FFFF);
    check("comp_ones",   {26'd0, ones_q_o},   32'd32);
    check("comp_parity", {31'd0, parity_q_o}, 32'd0);
    check("comp_zero",   {31'd0, zero_q_o},   32'd0);

    // mixed pattern: F0000004 -> 5 ones, odd parity
    a_i = 32'hFF00_1234; b_i = 32'h0F00_1230;
    tick();
    check("mix_c_q",    c_q_o,               32'hF000_0004);
    check("mix_ones",   {26'd0, ones_q_o},   32'd5);
    check("mix_parity", {31'd0, parity_q_o}, 32'd1);

    // single bit
    a_i = 32'h0000_0001; b_i = 32'd0;
    #1;
    check("bit_c_o", c_o, 32'd1);
    tick();
    check("bit_c_q",    c_q_o,               32'd1);
    check("bit_ones",   {26'd0, ones_q_o},   32'd1);
    check("bit_parity", {31'd0, parity_q_o}, 32'd1);
    check("bit_zero",   {31'd0, zero_q_o},   32'd0);

    // drop valid: pulse ends, registers hold
    valid_i = 1'b0; a_i = 32'h5; b_i = 32'h3;
    tick();
    check("hold_valid",  {31'd0, valid_o},    32'd0);
    check("hold_c_q",    c_q_o,               32'd1);
    check("hold_ones",   {26'd0, ones_q_o},   32'd1);
    check("hold_parity", {31'd0, parity_q_o}, 32'd1);

    // reset beats valid
    rst_i = 1'b1; valid_i = 1'b1; a_i = 32'hF0F0_F0F0; b_i = 32'h0F0F_0000;
    tick();
    check("rv_valid", {31'd0, valid_o},   32'd0);
    check("rv_c_q",   c_q_o,              32'd0);
    check("rv_zero",  {31'd0, zero_q_o},  32'd1);
    check("rv_ones",  {26'd0, ones_q_o},  32'd0);
    check("rv_c_o",   c_o,                32'hFFFF_F0F0);
    rst_i = 1'b0; valid_i = 1'b0;
    tick();

`ifdef XOR_32BIT_CHECKSUM_EN
    // same value twice cancels
    valid_i = 1'b1; a_i = 32'h1234_5678; b_i = 32'd0;
    tick();
    check("acc_first", acc_o, 32'h1234_5678);
    tick();
    check("acc_cancel", acc_o, 32'd0);
    a_i = 32'hA5A5_A5A5;
    tick();
    check("acc_a5", acc_o, 32'hA5A5_A5A5);
    valid_i = 1'b0;
    tick();
    check("acc_hold", acc_o, 32'hA5A5_A5A5);
    // clear wins over a concurrent capture
    clr_i = 1'b1; valid_i = 1'b1;
    tick();
    check("acc_clr", acc_o, 32'd0);
    clr_i = 1'b0; valid_i = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_xor_32bit_unit
